// File: rtl/axi_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pkg
//   Shared types for the AXI4-Lite register slave: response codes, the two
//   channel FSM state encodings and the byte-offset helper used for decode.
// ---------------------------------------------------------------------------
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    WR_IDLE,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_t;

  // Number of address bits that select a byte inside one data word.
  function automatic int calc_addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// ---------------------------------------------------------------------------
// axi_lite_if
//   AXI4-Lite AW/W/B/AR/R channel bundle.
//   Ports : ACLK, ARESETn (carried for masters that want them; the slave in
//           this codebase is clocked and reset through its own scalar ports).
//   Modports: master (drives addresses/data/ready-for-response),
//             slave  (drives channel readies and responses).
// ---------------------------------------------------------------------------
interface axi_lite_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input logic ACLK,
  input logic ARESETn
);

  logic [ADDRESS_WIDTH-1:0]  AWADDR;
  logic [2:0]                AWPROT;
  logic                      AWVALID;
  logic                      AWREADY;

  logic [DATA_WIDTH-1:0]     WDATA;
  logic [DATA_WIDTH/8-1:0]   WSTRB;
  logic                      WVALID;
  logic                      WREADY;

  logic [1:0]                BRESP;
  logic                      BVALID;
  logic                      BREADY;

  logic [ADDRESS_WIDTH-1:0]  ARADDR;
  logic [2:0]                ARPROT;
  logic                      ARVALID;
  logic                      ARREADY;

  logic [DATA_WIDTH-1:0]     RDATA;
  logic [1:0]                RRESP;
  logic                      RVALID;
  logic                      RREADY;

  modport master (
    input  ACLK, ARESETn,
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID,    input WREADY,
    input  BRESP, BVALID,           output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input  RDATA, RRESP, RVALID,    output RREADY
  );

  modport slave (
    input  ACLK, ARESETn,
    input  AWADDR, AWPROT, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID,    output WREADY,
    output BRESP, BVALID,           input BREADY,
    input  ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID,    input RREADY
  );

endinterface

// File: rtl/axi4_lite_reg_bank.sv
// ---------------------------------------------------------------------------
// axi4_lite_reg_bank
//   Register storage behind the AXI4-Lite slave.
//   Words 0..NUM_RO-1 are live views of ro_status_i; the rest are RW flops
//   written with per-byte strobes.
//   Ports : ACLK, ARESET (async, active high)
//           wr_en/wr_idx/wr_data/wr_strb  - commit request from the write FSM
//           wr_ok                         - wr_idx addresses an RW word
//           rd_idx -> rd_data, rd_ok      - combinational read mux (0 if out of range)
//           ro_status_i                   - read-only word sources, word 0 at LSBs
//           regs_o                        - flattened bank contents
//           wr_pulse_o                    - one-cycle strobe after a committed write
// ---------------------------------------------------------------------------
module axi4_lite_reg_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int NUM_RO     = 2,
  parameter int IDX_W      = 30
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic                           wr_en,
  input  logic [IDX_W-1:0]               wr_idx,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH/8-1:0]        wr_strb,
  output logic                           wr_ok,
  input  logic [IDX_W-1:0]               rd_idx,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic                           rd_ok,
  input  logic [NUM_RO*DATA_WIDTH-1:0]   ro_status_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int NB = DATA_WIDTH / 8;

  logic [NUM_REGS*DATA_WIDTH-1:0] bank_flat;
  logic [NUM_REGS-1:0]            pulse_d;

  // The index carries every address bit above the byte offset, so addresses
  // past the bank are rejected instead of aliasing onto low words.
  assign wr_ok = (wr_idx >= IDX_W'(NUM_RO)) && (wr_idx < IDX_W'(NUM_REGS));
  assign rd_ok = (rd_idx < IDX_W'(NUM_REGS));

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_word
    if (i < NUM_RO) begin : g_ro
      assign bank_flat[i*DATA_WIDTH +: DATA_WIDTH] = ro_status_i[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] word_q;
      logic                  hit;

      assign hit = wr_en && (wr_idx == IDX_W'(i));

      // NOTE: the control words drive hardware directly, so every RW word is
      // reset explicitly; this bank is flops, not a RAM macro.
      always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
          word_q <= '0;
        end else if (hit) begin
          for (int b = 0; b < NB; b++) begin
            if (wr_strb[b]) word_q[b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end

      assign bank_flat[i*DATA_WIDTH +: DATA_WIDTH] = word_q;
    end
  end

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it holding a value (no latch).
  always_comb begin
    pulse_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pulse_d[i] = wr_en && wr_ok && (wr_idx == IDX_W'(i));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // pre-edge values regardless of process ordering.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) wr_pulse_o <= '0;
    else        wr_pulse_o <= pulse_d;
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_data = bank_flat[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign regs_o = bank_flat;

endmodule

// File: rtl/axi4_lite_slave.sv
// ---------------------------------------------------------------------------
// axi4_lite_slave
//   AXI4-Lite responder in front of axi4_lite_reg_bank. Holds only the write
//   and read channel FSMs; they run concurrently.
//   Ports : ACLK, ARESET (async, active high)
//           axi         - AXI4-Lite slave modport (PROT ignored)
//           ro_status_i - live values for the read-only words, word 0 at LSBs
//           regs_o      - current bank contents
//           wr_pulse_o  - per-word strobe the cycle after a committed write
// ---------------------------------------------------------------------------
module axi4_lite_slave
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int NUM_REGS      = 8,
  parameter int NUM_RO        = 2
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  axi_lite_if.slave                      axi,
  input  logic [NUM_RO*DATA_WIDTH-1:0]   ro_status_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int ADDR_LSB = calc_addr_lsb(DATA_WIDTH);
  localparam int IDX_W    = ADDRESS_WIDTH - ADDR_LSB;
  localparam int STRB_W   = DATA_WIDTH / 8;

  // ---------------- write channel ----------------
  wr_state_t             wr_state, wr_state_d;
  logic                  aw_got, w_got;
  logic [IDX_W-1:0]      aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  resp_t                 bresp_q;
  logic                  awready, wready, bvalid;
  logic                  aw_hs, w_hs, wr_commit, wr_ok;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;

  // ---------------- read channel -----------------
  rd_state_t             rd_state, rd_state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rd_data;
  resp_t                 rresp_q;
  logic                  arready, rvalid, ar_hs, rd_ok;

  assign aw_hs = axi.AWVALID && axi.AWREADY;
  assign w_hs  = axi.WVALID  && axi.WREADY;
  assign ar_hs = axi.ARVALID && axi.ARREADY;

  // The second of AW/W commits on its own handshake edge, so the bank is fed
  // live bus values for whichever half is arriving now.
  assign wr_commit = (wr_state == WR_IDLE) && (aw_got || aw_hs) && (w_got || w_hs);
  assign wr_idx    = aw_got ? aw_idx_q : axi.AWADDR[ADDR_LSB +: IDX_W];
  assign wr_data   = w_got  ? w_data_q : axi.WDATA;
  assign wr_strb   = w_got  ? w_strb_q : axi.WSTRB;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) wr_state <= WR_IDLE;
    else        wr_state <= wr_state_d;
  end

  always_comb begin
    wr_state_d = wr_state;
    awready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        awready = !aw_got;
        wready  = !w_got;
        if (wr_commit) wr_state_d = WR_RESP;
      end
      WR_RESP: begin
        bvalid = 1'b1;
        if (axi.BREADY) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bresp_q  <= OKAY;
    end else if (wr_state == WR_IDLE) begin
      if (wr_commit) begin
        aw_got  <= 1'b0;
        w_got   <= 1'b0;
        bresp_q <= wr_ok ? OKAY : SLVERR;
      end else begin
        if (aw_hs) begin
          aw_got   <= 1'b1;
          aw_idx_q <= axi.AWADDR[ADDR_LSB +: IDX_W];
        end
        if (w_hs) begin
          w_got    <= 1'b1;
          w_data_q <= axi.WDATA;
          w_strb_q <= axi.WSTRB;
        end
      end
    end
  end

  // Readies are masked by reset so nothing looks acceptable while it is held.
  assign axi.AWREADY = awready && !ARESET;
  assign axi.WREADY  = wready  && !ARESET;
  assign axi.BVALID  = bvalid;
  assign axi.BRESP   = bresp_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) rd_state <= RD_IDLE;
    else        rd_state <= rd_state_d;
  end

  always_comb begin
    rd_state_d = rd_state;
    arready    = 1'b0;
    rvalid     = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        arready = 1'b1;
        if (axi.ARVALID) rd_state_d = RD_RESP;
      end
      RD_RESP: begin
        rvalid = 1'b1;
        if (axi.RREADY) rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Sampled on the AR edge: a write committing on the same edge is not yet
  // visible, so the read returns the pre-write word.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rdata_q <= '0;
      rresp_q <= OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_data;
      rresp_q <= rd_ok ? OKAY : SLVERR;
    end
  end

  assign axi.ARREADY = arready && !ARESET;
  assign axi.RVALID  = rvalid;
  assign axi.RDATA   = rdata_q;
  assign axi.RRESP   = rresp_q;

  axi4_lite_reg_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .NUM_RO     (NUM_RO),
    .IDX_W      (IDX_W)
  ) u_bank (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .wr_en       (wr_commit),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
    .wr_strb     (wr_strb),
    .wr_ok       (wr_ok),
    .rd_idx      (axi.ARADDR[ADDR_LSB +: IDX_W]),
    .rd_data     (rd_data),
    .rd_ok       (rd_ok),
    .ro_status_i (ro_status_i),
    .regs_o      (regs_o),
    .wr_pulse_o  (wr_pulse_o)
  );

  // Byte-offset bits, PROT and the interface's own clock/reset are
  // intentionally ignored.
  logic unused_ok;
  assign unused_ok = ^{axi.ACLK, axi.ARESETn, axi.AWPROT, axi.ARPROT,
                       axi.AWADDR[ADDR_LSB-1:0], axi.ARADDR[ADDR_LSB-1:0]};

endmodule

// File: tb/tb_axi4_lite_slave.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_slave
//   Directed bench for axi4_lite_slave. Drivers push expected B/R responses
//   and write pulses into queues; an independent negedge monitor pops and
//   compares whenever the DUT presents a response or pulse.
// ---------------------------------------------------------------------------
module tb_axi4_lite_slave;

  localparam int DW      = 32;
  localparam int AW      = 32;
  localparam int NREG    = 8;
  localparam int NRO     = 2;
  localparam int TIMEOUT = 50;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  logic                ACLK;
  logic                ARESET;
  logic [NRO*DW-1:0]   ro_status_i;
  logic [NREG*DW-1:0]  regs_o;
  logic [NREG-1:0]     wr_pulse_o;

  axi_lite_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) axi (.ACLK(ACLK), .ARESETn(!ARESET));

  axi4_lite_slave #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REGS(NREG), .NUM_RO(NRO)
  ) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .axi         (axi),
    .ro_status_i (ro_status_i),
    .regs_o      (regs_o),
    .wr_pulse_o  (wr_pulse_o)
  );

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [1:0]  b_q[$];
  r_exp_t      r_q[$];
  logic [7:0]  p_q[$];

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (axi.BVALID) begin
        check("aw_w_blocked_in_resp", 32'({axi.AWREADY, axi.WREADY}), 32'd0);
        if (b_q.size() != 0) check("bresp_held", 32'(axi.BRESP), 32'(b_q[0]));
        if (axi.BREADY) begin
          check("b_expected", 32'(b_q.size() != 0), 32'd1);
          if (b_q.size() != 0) check("bresp", 32'(axi.BRESP), 32'(b_q.pop_front()));
        end
      end
      if (axi.RVALID) begin
        if (r_q.size() != 0) check("rdata_held", axi.RDATA, r_q[0].data);
        if (axi.RREADY) begin
          check("r_expected", 32'(r_q.size() != 0), 32'd1);
          if (r_q.size() != 0) begin
            r_exp_t e;
            e = r_q.pop_front();
            check("rdata", axi.RDATA, e.data);
            check("rresp", 32'(axi.RRESP), 32'(e.resp));
          end
        end
      end
      if (wr_pulse_o != '0) begin
        check("pulse_expected", 32'(p_q.size() != 0), 32'd1);
        if (p_q.size() != 0) check("wr_pulse", 32'(wr_pulse_o), 32'(p_q.pop_front()));
      end
    end
  end

  // ---------------- channel drivers ----------------
  task automatic do_aw_w(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int aw_delay, input int w_delay);
    fork
      begin
        bit hs;
        int n;
        repeat (aw_delay) begin @(posedge ACLK); #1; end
        axi.AWADDR  = addr;
        axi.AWVALID = 1'b1;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < TIMEOUT) begin
          @(negedge ACLK); hs = axi.AWREADY;
          @(posedge ACLK); #1; n++;
        end
        check("aw_handshake", 32'(hs), 32'd1);
        axi.AWVALID = 1'b0;
      end
      begin
        bit hs;
        int n;
        repeat (w_delay) begin @(posedge ACLK); #1; end
        axi.WDATA  = data;
        axi.WSTRB  = strb;
        axi.WVALID = 1'b1;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < TIMEOUT) begin
          @(negedge ACLK); hs = axi.WREADY;
          @(posedge ACLK); #1; n++;
        end
        check("w_handshake", 32'(hs), 32'd1);
        axi.WVALID = 1'b0;
      end
    join
  endtask

  task automatic do_b(input int b_hold);
    bit hs;
    int n;
    repeat (b_hold) begin @(posedge ACLK); #1; end
    axi.BREADY = 1'b1;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < TIMEOUT) begin
      @(negedge ACLK); hs = axi.BVALID;
      @(posedge ACLK); #1; n++;
    end
    check("b_handshake", 32'(hs), 32'd1);
    axi.BREADY = 1'b0;
  endtask

  task automatic do_ar(input logic [31:0] addr);
    bit hs;
    int n;
    axi.ARADDR  = addr;
    axi.ARVALID = 1'b1;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < TIMEOUT) begin
      @(negedge ACLK); hs = axi.ARREADY;
      @(posedge ACLK); #1; n++;
    end
    check("ar_handshake", 32'(hs), 32'd1);
    axi.ARVALID = 1'b0;
  endtask

  task automatic do_r(input int r_hold);
    bit hs;
    int n;
    repeat (r_hold) begin @(posedge ACLK); #1; end
    axi.RREADY = 1'b1;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < TIMEOUT) begin
      @(negedge ACLK); hs = axi.RVALID;
      @(posedge ACLK); #1; n++;
    end
    check("r_handshake", 32'(hs), 32'd1);
    axi.RREADY = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp,
                           input logic [7:0] pulse, input int aw_delay,
                           input int w_delay, input int b_hold);
    b_q.push_back(resp);
    if (pulse != 8'h00) p_q.push_back(pulse);
    do_aw_w(addr, data, strb, aw_delay, w_delay);
    do_b(b_hold);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] resp, input int r_hold);
    r_exp_t e;
    e.data = data;
    e.resp = resp;
    r_q.push_back(e);
    do_ar(addr);
    do_r(r_hold);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    ARESET      = 1'b1;
    ro_status_i = {32'h1111_2222, 32'hA5A5_A5A5};
    axi.AWADDR  = '0; axi.AWPROT = '0; axi.AWVALID = 1'b0;
    axi.WDATA   = '0; axi.WSTRB  = '0; axi.WVALID  = 1'b0;
    axi.BREADY  = 1'b0;
    axi.ARADDR  = '0; axi.ARPROT = '0; axi.ARVALID = 1'b0;
    axi.RREADY  = 1'b0;

    repeat (3) @(posedge ACLK);
    #1;
    check("rst_awready", 32'(axi.AWREADY), 32'd0);
    check("rst_arready", 32'(axi.ARREADY), 32'd0);
    check("rst_bvalid",  32'(axi.BVALID),  32'd0);
    check("rst_rvalid",  32'(axi.RVALID),  32'd0);
    check("rst_pulse",   32'(wr_pulse_o),  32'd0);
    check("rst_word2",   regs_o[2*DW +: DW], 32'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    check("idle_ready", 32'({axi.AWREADY, axi.WREADY, axi.ARREADY}), 32'h7);

    // Full-word write then read back.
    axi_write(32'h0C, 32'hDEAD_BEEF, 4'hF, 2'b00, 8'h08, 0, 0, 0);
    check("regs_o_word3", regs_o[3*DW +: DW], 32'hDEAD_BEEF);
    axi_read(32'h0C, 32'hDEAD_BEEF, 2'b00, 0);

    // Byte strobes over a preloaded word.
    axi_write(32'h10, 32'hFFFF_FFFF, 4'hF,    2'b00, 8'h10, 0, 0, 0);
    axi_write(32'h10, 32'h1234_5678, 4'b0101, 2'b00, 8'h10, 0, 0, 0);
    axi_read(32'h10, 32'hFF34_FF78, 2'b00, 0);

    // Out of range: SLVERR, no pulse, read returns 0.
    axi_write(32'h20, 32'h0BAD_0BAD, 4'hF, 2'b10, 8'h00, 0, 0, 0);
    axi_read(32'h20, 32'h0000_0000, 2'b10, 0);

    // Read-only words reject writes and mirror ro_status_i.
    axi_write(32'h00, 32'h0000_0000, 4'hF, 2'b10, 8'h00, 0, 0, 0);
    axi_read(32'h00, 32'hA5A5_A5A5, 2'b00, 0);
    axi_read(32'h04, 32'h1111_2222, 2'b00, 0);

    // Byte-offset address bits are ignored.
    axi_write(32'h1F, 32'hCAFE_F00D, 4'hF, 2'b00, 8'h80, 0, 0, 0);
    axi_read(32'h1D, 32'hCAFE_F00D, 2'b00, 0);

    // W three cycles ahead of AW, B back-pressured for 4 cycles.
    axi_write(32'h18, 32'h0BAD_F00D, 4'hF, 2'b00, 8'h40, 3, 0, 4);
    axi_read(32'h18, 32'h0BAD_F00D, 2'b00, 2);

    // Read and write to the same word on the same edge: read sees old value.
    fork
      axi_write(32'h14, 32'h600D_CAFE, 4'hF, 2'b00, 8'h20, 0, 0, 0);
      axi_read(32'h14, 32'h0000_0000, 2'b00, 0);
    join
    axi_read(32'h14, 32'h600D_CAFE, 2'b00, 0);

    // Reset with both responses pending.
    b_q.push_back(2'b00);
    p_q.push_back(8'h08);
    do_aw_w(32'h0C, 32'h7777_8888, 4'hF, 0, 0);
    begin
      r_exp_t e;
      e.data = 32'h7777_8888;
      e.resp = 2'b00;
      r_q.push_back(e);
    end
    do_ar(32'h0C);
    @(negedge ACLK);
    check("pend_bvalid", 32'(axi.BVALID), 32'd1);
    check("pend_rvalid", 32'(axi.RVALID), 32'd1);
    #2;
    ARESET = 1'b1;
    #1;
    check("abort_valids", 32'({axi.BVALID, axi.RVALID}), 32'd0);
    check("abort_readys", 32'({axi.AWREADY, axi.WREADY, axi.ARREADY}), 32'd0);
    check("abort_word3",  regs_o[3*DW +: DW], 32'd0);
    check("abort_word4",  regs_o[4*DW +: DW], 32'd0);
    b_q.delete();
    r_q.delete();
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    axi_read(32'h0C, 32'h0000_0000, 2'b00, 0);
    axi_read(32'h10, 32'h0000_0000, 2'b00, 0);
    axi_read(32'h00, 32'hA5A5_A5A5, 2'b00, 0);

    repeat (3) @(posedge ACLK);
    #1;
    check("b_queue_drained", 32'(b_q.size()), 32'd0);
    check("r_queue_drained", 32'(r_q.size()), 32'd0);
    check("p_queue_drained", 32'(p_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
